hex_scan_ctrl: RTL and testbench
================================

# hex_scan_ctrl

- Time-multiplexed scan controller for the board's common-anode seven-segment bank.
- Owns a double-buffered digit store: a shadow buffer written through a valid/ready port, and an active buffer that drives the display.
- A commit request swaps shadow to active only at a frame boundary, so no digit ever tears.
- Sits between the switch/arith datapath blocks and the physical `hex`/`an` pins; replaces per-digit static decoders.

## Interface
Parameters:
- `DIGITS`, 8: number of digits scanned (2..8).
- `REFRESH_DIV`, 100000: clock cycles per digit slot (≥ `BLANK`+2).
- `BLANK`, 2: guard cycles at slot start with all anodes off (anti-ghosting, ≥1).

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `wr_valid`  in  1  shadow write request.
- `wr_ready`  out  1  shadow port can accept a write.
- `wr_addr`  in  3  digit index; writes with `wr_addr` ≥ `DIGITS` are accepted and dropped.
- `wr_data`  in  4  hex nibble.
- `wr_en`  in  1  digit enable; 0 blanks that digit.
- `wr_dp`  in  1  decimal point, 1 = lit.
- `commit`  in  1  single-cycle pulse: request shadow→active swap.
- `frame_start`  out  1  one-cycle pulse when slot 0 begins.
- `an`  out  `DIGITS`  anodes, active-low.
- `hex`  out  7  segments {g..a}, active-low.
- `dp`  out  1  decimal point, active-low.

## Operation
- Transfer: write occurs when `wr_valid && wr_ready`. It updates shadow entry `wr_addr` (data, en, dp) on that edge.
- `wr_ready` = !`pend`, where `pend` is the pending-commit flag.
- `commit` sets `pend`. `commit` while `pend` = 1 is ignored.
- Swap: at the last cycle of slot `DIGITS-1` with `pend` = 1:
  - all shadow entries copy to active;
  - `pend` clears;
  - the new contents are visible from slot 0 of the next frame.
- Same-cycle `commit` and write: the write lands in shadow first (`wr_ready` was 1), then `pend` sets.
- Same-cycle `commit` and swap edge, with `pend` = 0: the commit is not taken this frame; it swaps at the end of the next frame.
- Two-state FSM per slot:
  - `S_BLANK`: `BLANK` cycles; `an` all 1s, `hex` = 7'h7F, `dp` = 1.
  - `S_ON`: remaining `REFRESH_DIV-BLANK` cycles; `an[idx]` = 0 and all other anodes 1.
  - In `S_ON`, if active en[idx] = 0, then `hex` = 7'h7F and `dp` = 1; otherwise the segments are decoded from the nibble.
- Slot counter `cnt` runs 0..`REFRESH_DIV-1`.
  - At terminal count: `cnt` → 0, `idx` → `idx+1`, wrapping `DIGITS-1` → 0; FSM → `S_BLANK`.
  - `cnt` == `BLANK-1` in `S_BLANK` moves to `S_ON`.
- Decode (gfedcba, active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Counter widths: `cnt` is $clog2(`REFRESH_DIV`) bits; `idx` is 3 bits.

## Timing
- All outputs are registered.
- `an`/`hex`/`dp` change one cycle after the `cnt`/FSM state that selects them.
- Reset values:
  - outputs: `an` all 1s, `hex` 7'h7F, `dp` 1, `wr_ready` 1, `frame_start` 0;
  - internal: `cnt` 0, `idx` 0, `S_BLANK`;
  - both buffers cleared (data 0, en 0, dp 0), `pend` 0.
- Reset mid-frame or mid-pending abandons the pending commit; the display goes dark on the next cycle.
- `frame_start` is high for exactly one cycle, at `cnt` == 0 with `idx` == 0. The first pulse comes one cycle after reset deassertion.
- Commit-to-display latency: at most `DIGITS*REFRESH_DIV`+1 cycles.
- Write accepted, then re-read by the display: never before the next swap.

## Configuration
- `HEX_SCAN_DIM_EN` defined:
  - adds input `dim` [1:0];
  - in `S_ON`, the anode is driven only while (`cnt`-`BLANK`) < ((`REFRESH_DIV`-`BLANK`)*(`dim`+1))/4;
  - outside that window, outputs are as in `S_BLANK`;
  - `dim` = 3 is full brightness;
  - `dim` is sampled at every slot start.
- Undefined: no `dim` port; full on-time in `S_ON`.

## Test plan
Bench parameters: `DIGITS`=4, `REFRESH_DIV`=6, `BLANK`=1.
- Reset held 3 cycles then released:
  - `an`=4'b1111, `hex`=7'h7F on all reset cycles;
  - `frame_start` pulses 1 cycle after release, then every 24 cycles.
- Write digits 0..3 = {1,2,3,F}, all en=1, then `commit`:
  - `wr_ready` low until the frame end;
  - next frame shows `an`=1110/hex 1111001, then 1101/0100100, then 1011/0110000, then 0111/0001110;
  - each digit is on for 5 cycles after 1 blank cycle.
- Write while `pend`=1:
  - `wr_ready`=0, so the write is not taken;
  - the shadow entry is unchanged after the swap, confirmed by writing after the swap and committing.
- `commit` asserted on the exact swap cycle with `pend`=0:
  - no swap this frame; the swap happens at the end of the following frame;
  - `wr_ready` is low for that whole frame.
- en=0 on digit 2, dp=1 on digit 0:
  - slot 2 shows `an` all 1s equivalent output (`hex` 7'h7F);
  - slot 0 shows `dp`=0.
- `HEX_SCAN_DIM_EN`, `dim`=1, `REFRESH_DIV`=9, `BLANK`=1: the anode is active for 4 of the 8 `S_ON` cycles per slot.

Source files
------------

// File: rtl/hex_scan_ctrl.sv
// Scan controller for a common-anode seven-segment bank with a double-buffered digit store.
// Optional brightness control is compiled in with `define HEX_SCAN_DIM_EN.
//   state   | meaning
//   S_BLANK | guard cycles at slot start, all anodes off
//   S_ON    | current digit anode driven (within the dim window)
module hex_scan_ctrl #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [2:0]        wr_addr,
  input  logic [3:0]        wr_data,
  input  logic              wr_en,
  input  logic              wr_dp,
  input  logic              commit,
`ifdef HEX_SCAN_DIM_EN
  input  logic [1:0]        dim,
`endif
  output logic              frame_start,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        hex,
  output logic              dp
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);

  typedef enum logic {S_BLANK, S_ON} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt;
  logic [2:0]             idx;
  logic [IW-1:0]          idx_s;
  logic                   pend;
  logic [DIGITS-1:0][3:0] sh_data, ac_data;
  logic [DIGITS-1:0]      sh_en, sh_dp, ac_en, ac_dp;
  logic                   tc, frame_end, wr_fire, wr_in_range, lit_win;
  logic [DIGITS-1:0]      an_nxt;
  logic [6:0]             hex_nxt;
  logic                   dp_nxt;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  assign idx_s       = idx[IW-1:0];
  assign tc          = (cnt == CW'(REFRESH_DIV - 1));
  assign frame_end   = tc && (idx == 3'(DIGITS - 1));
  assign wr_ready    = ~pend;
  assign wr_fire     = wr_valid && !pend;
  assign wr_in_range = (32'(wr_addr) < 32'(DIGITS));

`ifdef HEX_SCAN_DIM_EN
  // dim_q is captured at cnt==0, so it is stable before any S_ON cycle of the slot.
  logic [1:0]  dim_q;
  logic [31:0] on_lim, on_off;

  always_comb begin
    on_lim = 32'(REFRESH_DIV - BLANK);
    case (dim_q)
      2'd0: on_lim = 32'((REFRESH_DIV - BLANK) / 4);
      2'd1: on_lim = 32'(((REFRESH_DIV - BLANK) * 2) / 4);
      2'd2: on_lim = 32'(((REFRESH_DIV - BLANK) * 3) / 4);
      default: on_lim = 32'(REFRESH_DIV - BLANK);
    endcase
    on_off  = 32'(cnt) - 32'(BLANK);
    lit_win = (on_off < on_lim);
  end

  always_ff @(posedge clk) begin
    if (rst) dim_q <= 2'd3;
    else if (cnt == '0) dim_q <= dim;
  end
`else
  assign lit_win = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    an_nxt    = '1;
    hex_nxt   = 7'h7F;
    dp_nxt    = 1'b1;
    if (tc) state_nxt = S_BLANK;
    else if (state == S_BLANK && cnt == CW'(BLANK - 1)) state_nxt = S_ON;
    if (state == S_ON && lit_win) begin
      an_nxt = ~(DIGITS'(1) << idx_s);
      if (ac_en[idx_s]) begin
        hex_nxt = seg7(ac_data[idx_s]);
        dp_nxt  = ~ac_dp[idx_s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_BLANK;
      cnt         <= '0;
      idx         <= '0;
      pend        <= 1'b0;
      sh_data     <= '0;
      sh_en       <= '0;
      sh_dp       <= '0;
      ac_data     <= '0;
      ac_en       <= '0;
      ac_dp       <= '0;
      an          <= '1;
      hex         <= 7'h7F;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      an          <= an_nxt;
      hex         <= hex_nxt;
      dp          <= dp_nxt;
      frame_start <= (cnt == '0) && (idx == '0);
      if (tc) begin
        cnt <= '0;
        idx <= (idx == 3'(DIGITS - 1)) ? 3'd0 : idx + 3'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (wr_fire && wr_in_range) begin
        sh_data[wr_addr[IW-1:0]] <= wr_data;
        sh_en[wr_addr[IW-1:0]]   <= wr_en;
        sh_dp[wr_addr[IW-1:0]]   <= wr_dp;
      end
      // A commit arriving on the swap edge with nothing pending waits a full frame.
      if (frame_end && pend) begin
        ac_data <= sh_data;
        ac_en   <= sh_en;
        ac_dp   <= sh_dp;
        pend    <= 1'b0;
      end else if (commit) begin
        pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Randomized bench for hex_scan_ctrl against a frame-position reference model.
// Builds with or without HEX_SCAN_DIM_EN.
module tb_hex_scan_ctrl;
  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 6;
  localparam int BLANK       = 1;
  localparam int FRAME       = DIGITS * REFRESH_DIV;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid = 1'b0;
  logic [2:0]        wr_addr = '0;
  logic [3:0]        wr_data = '0;
  logic              wr_en = 1'b0;
  logic              wr_dp = 1'b0;
  logic              commit = 1'b0;
  logic              wr_ready, frame_start, dp;
  logic [DIGITS-1:0] an;
  logic [6:0]        hex;
`ifdef HEX_SCAN_DIM_EN
  logic [1:0]        dim = 2'd3;
`endif

  always #5 clk = ~clk;

  hex_scan_ctrl #(.DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_en(wr_en), .wr_dp(wr_dp), .commit(commit),
`ifdef HEX_SCAN_DIM_EN
    .dim(dim),
`endif
    .frame_start(frame_start), .an(an), .hex(hex), .dp(dp)
  );

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int n_cmp = 0;
  int n_err = 0;

  // reference model: two digit tables, pending flag, cycles since reset release
  logic [3:0] m_sh_data [DIGITS];
  logic       m_sh_en   [DIGITS];
  logic       m_sh_dp   [DIGITS];
  logic [3:0] m_ac_data [DIGITS];
  logic       m_ac_en   [DIGITS];
  logic       m_ac_dp   [DIGITS];
  logic       m_pend = 1'b0;
  int         m_tm = 0;
  int         m_dim = 3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    logic [DIGITS-1:0] e_an;
    logic [6:0]        e_hex;
    logic              e_dp, e_fs, lit;
    int                p, s, c;
    @(posedge clk);
    e_an = '1; e_hex = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) begin
        m_sh_data[i] = '0; m_sh_en[i] = 1'b0; m_sh_dp[i] = 1'b0;
        m_ac_data[i] = '0; m_ac_en[i] = 1'b0; m_ac_dp[i] = 1'b0;
      end
      m_pend = 1'b0;
      m_tm   = 0;
      m_dim  = 3;
    end else begin
      p = m_tm % FRAME;
      s = p / REFRESH_DIV;
      c = p % REFRESH_DIV;
      lit = (c >= BLANK);
`ifdef HEX_SCAN_DIM_EN
      if (lit) lit = (c - BLANK) < ((REFRESH_DIV - BLANK) * (m_dim + 1)) / 4;
      if (c == 0) m_dim = int'(dim);
`endif
      e_fs = (p == 0);
      if (lit) begin
        e_an = ~(DIGITS'(1) << s);
        if (m_ac_en[s]) begin
          e_hex = seg_tab[m_ac_data[s]];
          e_dp  = ~m_ac_dp[s];
        end
      end
      if (wr_valid && !m_pend && int'(wr_addr) < DIGITS) begin
        m_sh_data[wr_addr] = wr_data;
        m_sh_en[wr_addr]   = wr_en;
        m_sh_dp[wr_addr]   = wr_dp;
      end
      if (p == FRAME - 1 && m_pend) begin
        for (int i = 0; i < DIGITS; i++) begin
          m_ac_data[i] = m_sh_data[i];
          m_ac_en[i]   = m_sh_en[i];
          m_ac_dp[i]   = m_sh_dp[i];
        end
        m_pend = 1'b0;
      end else if (commit) begin
        m_pend = 1'b1;
      end
      m_tm++;
    end
    #1;
    chk("an", 32'(an), 32'(e_an));
    chk("hex", 32'(hex), 32'(e_hex));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("wr_ready", 32'(wr_ready), 32'(!m_pend));
  endtask

  task automatic idle(input int n);
    wr_valid = 1'b0;
    commit   = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic wr(input int a, input int d, input bit en, input bit dpv, input bit cmt);
    wr_valid = 1'b1;
    wr_addr  = 3'(a);
    wr_data  = 4'(d);
    wr_en    = en;
    wr_dp    = dpv;
    commit   = cmt;
    cycle();
    wr_valid = 1'b0;
    commit   = 1'b0;
  endtask

  // drive so that the next edge is the swap edge; a miss is a failed comparison
  task automatic wait_swap_edge();
    int k;
    k = 0;
    while ((m_tm % FRAME) != FRAME - 1 && k < 2 * FRAME) begin
      cycle();
      k++;
    end
    chk("swap_wait", 32'((m_tm % FRAME) == FRAME - 1), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    idle(2);

    wr(0, 4'h1, 1, 0, 0);
    wr(1, 4'h2, 1, 0, 0);
    wr(2, 4'h3, 1, 0, 0);
    wr(3, 4'hF, 1, 0, 1);
    idle(2 * FRAME);

    wr(0, 4'h5, 1, 0, 1);
    wr(1, 4'h9, 1, 1, 0);
    idle(2 * FRAME);
    wr(2, 4'hA, 1, 0, 1);
    idle(2 * FRAME);

    wr(3, 4'h7, 1, 0, 0);
    wait_swap_edge();
    commit = 1'b1;
    cycle();
    commit = 1'b0;
    idle(2 * FRAME + 2);

    wr(2, 4'h0, 0, 0, 0);
    wr(0, 4'h8, 1, 1, 0);
    wr(6, 4'hC, 1, 1, 1);
    idle(2 * FRAME);

    repeat (1500) begin
      rst      = ($urandom_range(0, 399) == 0);
      wr_valid = 1'($urandom);
      wr_addr  = 3'($urandom);
      wr_data  = 4'($urandom);
      wr_en    = 1'($urandom);
      wr_dp    = 1'($urandom);
      commit   = ($urandom_range(0, 23) == 0);
`ifdef HEX_SCAN_DIM_EN
      dim      = 2'($urandom);
`endif
      cycle();
    end
    rst = 1'b0;

    wr(1, 4'hE, 1, 1, 1);
    idle(3);
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    idle(2 * FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
